// File: rtl/alu_rs_scheduler.sv
// Integer ALU reservation station: holds dispatched micro-ops until both operands
// are captured, then issues the oldest ready entry into a registered operand bundle.
module alu_rs_scheduler #(
  parameter int NUM_ENTRIES   = 4,
  parameter int CDB_PORTS     = 3,
  parameter int ROB_IDX_WIDTH = 5,
  parameter int OP_WIDTH      = 17,
  parameter int DATA_WIDTH    = 32
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                flush,
  input  logic                                disp_valid,
  output logic                                disp_ready,
  input  logic [OP_WIDTH-1:0]                 disp_op,
  input  logic [ROB_IDX_WIDTH-1:0]            disp_rob_idx,
  input  logic                                disp_src1_rdy,
  input  logic                                disp_src2_rdy,
  input  logic [ROB_IDX_WIDTH-1:0]            disp_src1_tag,
  input  logic [ROB_IDX_WIDTH-1:0]            disp_src2_tag,
  input  logic [DATA_WIDTH-1:0]               disp_src1_val,
  input  logic [DATA_WIDTH-1:0]               disp_src2_val,
  input  logic [DATA_WIDTH-1:0]               disp_imm,
  input  logic [CDB_PORTS-1:0]                cdb_valid,
  input  logic [CDB_PORTS*ROB_IDX_WIDTH-1:0]  cdb_tag,
  input  logic [CDB_PORTS*DATA_WIDTH-1:0]     cdb_value,
  input  logic                                issue_ready,
  output logic                                issue_valid,
  output logic [OP_WIDTH-1:0]                 issue_op,
  output logic [ROB_IDX_WIDTH-1:0]            issue_rob_idx,
  output logic [DATA_WIDTH-1:0]               issue_src1,
  output logic [DATA_WIDTH-1:0]               issue_src2,
  output logic [DATA_WIDTH-1:0]               issue_imm,
  output logic [$clog2(NUM_ENTRIES+1)-1:0]    occupancy
);

  localparam int IDX_W = $clog2(NUM_ENTRIES);
  localparam int OCC_W = $clog2(NUM_ENTRIES+1);

  logic [NUM_ENTRIES-1:0]   ent_vld, s1_rdy, s2_rdy;
  logic [OP_WIDTH-1:0]      ent_op  [NUM_ENTRIES];
  logic [ROB_IDX_WIDTH-1:0] ent_rob [NUM_ENTRIES];
  logic [ROB_IDX_WIDTH-1:0] s1_tag  [NUM_ENTRIES];
  logic [ROB_IDX_WIDTH-1:0] s2_tag  [NUM_ENTRIES];
  logic [DATA_WIDTH-1:0]    s1_val  [NUM_ENTRIES];
  logic [DATA_WIDTH-1:0]    s2_val  [NUM_ENTRIES];
  logic [DATA_WIDTH-1:0]    ent_imm [NUM_ENTRIES];
  // older[i][j] set means entry i was dispatched before entry j
  logic [NUM_ENTRIES-1:0]   older   [NUM_ENTRIES];

  logic [NUM_ENTRIES-1:0]   eligible, blocked, sel_oh, wk1, wk2;
  logic [DATA_WIDTH-1:0]    wk1_val [NUM_ENTRIES];
  logic [DATA_WIDTH-1:0]    wk2_val [NUM_ENTRIES];
  logic [IDX_W-1:0]         sel_idx, free_idx;
  logic [DATA_WIDTH:0]      byp1, byp2;
  logic                     d1_rdy, d2_rdy, do_issue, do_disp;
  logic [DATA_WIDTH-1:0]    d1_val, d2_val;

  // Returns {hit, value}; the lowest matching port wins.
  function automatic logic [DATA_WIDTH:0] cdb_lookup(input logic [ROB_IDX_WIDTH-1:0] tag);
    logic [DATA_WIDTH:0] r;
    r = '0;
    for (int p = CDB_PORTS-1; p >= 0; p--) begin
      if (cdb_valid[p] && cdb_tag[p*ROB_IDX_WIDTH +: ROB_IDX_WIDTH] == tag)
        r = {1'b1, cdb_value[p*DATA_WIDTH +: DATA_WIDTH]};
    end
    return r;
  endfunction

  always_comb begin
    occupancy = '0;
    for (int i = 0; i < NUM_ENTRIES; i++)
      if (ent_vld[i]) occupancy = occupancy + OCC_W'(1);
  end

  assign disp_ready = (occupancy != OCC_W'(NUM_ENTRIES));
  assign eligible   = ent_vld & s1_rdy & s2_rdy;

  always_comb begin
    blocked  = '0;
    sel_oh   = '0;
    sel_idx  = '0;
    free_idx = '0;
    for (int i = 0; i < NUM_ENTRIES; i++) begin
      for (int j = 0; j < NUM_ENTRIES; j++)
        if (eligible[j] && older[j][i]) blocked[i] = 1'b1;
      sel_oh[i] = eligible[i] && !blocked[i];
    end
    for (int i = 0; i < NUM_ENTRIES; i++)
      if (sel_oh[i]) sel_idx = IDX_W'(i);
    for (int i = NUM_ENTRIES-1; i >= 0; i--)
      if (!ent_vld[i]) free_idx = IDX_W'(i);
  end

  always_comb begin
    wk1 = '0;
    wk2 = '0;
    for (int i = 0; i < NUM_ENTRIES; i++) begin
      logic [DATA_WIDTH:0] l1, l2;
      l1 = cdb_lookup(s1_tag[i]);
      l2 = cdb_lookup(s2_tag[i]);
      wk1[i]     = ent_vld[i] && !s1_rdy[i] && l1[DATA_WIDTH];
      wk2[i]     = ent_vld[i] && !s2_rdy[i] && l2[DATA_WIDTH];
      wk1_val[i] = l1[DATA_WIDTH-1:0];
      wk2_val[i] = l2[DATA_WIDTH-1:0];
    end
  end

  assign byp1     = cdb_lookup(disp_src1_tag);
  assign byp2     = cdb_lookup(disp_src2_tag);
  assign d1_rdy   = disp_src1_rdy || byp1[DATA_WIDTH];
  assign d2_rdy   = disp_src2_rdy || byp2[DATA_WIDTH];
  assign d1_val   = disp_src1_rdy ? disp_src1_val : byp1[DATA_WIDTH-1:0];
  assign d2_val   = disp_src2_rdy ? disp_src2_val : byp2[DATA_WIDTH-1:0];
  assign do_issue = issue_ready && (|eligible) && !flush;
  assign do_disp  = disp_valid && disp_ready && !flush;

  // Station -> issue register boundary (control and issue bundle)
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ent_vld       <= '0;
      s1_rdy        <= '0;
      s2_rdy        <= '0;
      for (int i = 0; i < NUM_ENTRIES; i++) older[i] <= '0;
      issue_valid   <= 1'b0;
      issue_op      <= '0;
      issue_rob_idx <= '0;
      issue_src1    <= '0;
      issue_src2    <= '0;
      issue_imm     <= '0;
    end else if (flush) begin
      ent_vld     <= '0;
      issue_valid <= 1'b0;
    end else begin
      issue_valid <= do_issue;
      for (int i = 0; i < NUM_ENTRIES; i++) begin
        if (wk1[i]) s1_rdy[i] <= 1'b1;
        if (wk2[i]) s2_rdy[i] <= 1'b1;
      end
      if (do_issue) begin
        ent_vld[sel_idx] <= 1'b0;
        issue_op         <= ent_op[sel_idx];
        issue_rob_idx    <= ent_rob[sel_idx];
        issue_src1       <= s1_val[sel_idx];
        issue_src2       <= s2_val[sel_idx];
        issue_imm        <= ent_imm[sel_idx];
      end
      if (do_disp) begin
        ent_vld[free_idx] <= 1'b1;
        s1_rdy[free_idx]  <= d1_rdy;
        s2_rdy[free_idx]  <= d2_rdy;
        for (int j = 0; j < NUM_ENTRIES; j++) begin
          older[j][free_idx] <= ent_vld[j];
          older[free_idx][j] <= 1'b0;
        end
      end
    end
  end

  // Entry payload: dispatch writes and CDB captures
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_ENTRIES; i++) begin
      if (wk1[i]) s1_val[i] <= wk1_val[i];
      if (wk2[i]) s2_val[i] <= wk2_val[i];
    end
    if (do_disp) begin
      ent_op[free_idx]  <= disp_op;
      ent_rob[free_idx] <= disp_rob_idx;
      s1_tag[free_idx]  <= disp_src1_tag;
      s2_tag[free_idx]  <= disp_src2_tag;
      s1_val[free_idx]  <= d1_val;
      s2_val[free_idx]  <= d2_val;
      ent_imm[free_idx] <= disp_imm;
    end
  end

endmodule
